// File: rtl/uart_rx_fifo.sv
// Asynchronous serial receiver feeding a show-ahead FIFO with per-word error flags.
// Optional build macro BREAK_DETECT_EN: report line breaks on break_det instead of queueing them.
module uart_rx_fifo #(
    parameter int CLOCK_HZ    = 27000000,
    parameter int BIT_RATE_HZ = 115200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          rx_data,
    output logic [DATA_BITS-1:0]          rx_word,
    output logic                          rx_frame_err,
    output logic                          rx_parity_err,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          overrun,
    input  logic                          clear_overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          break_det
);

    localparam int DIV = CLOCK_HZ / BIT_RATE_HZ;
    localparam int CW  = $clog2(DIV);
    localparam int BW  = $clog2(DATA_BITS);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int EW  = DATA_BITS + 2;

    localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_t;

    state_t               state, state_n;
    logic                 rx_meta, rxs;
    logic [CW-1:0]        cnt, cnt_n;
    logic [BW-1:0]        bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 ferr, ferr_n;
    logic                 perr, perr_n;
    logic                 stop_idx, stop_idx_n;
    logic                 tick, push, is_break;
`ifdef BREAK_DETECT_EN
    logic                 par_bit, par_bit_n;
`endif

    // Two-flop synchroniser; everything downstream sees only rxs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
            rx_meta <= rx_data;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            ferr     <= 1'b0;
            perr     <= 1'b0;
            stop_idx <= 1'b0;
`ifdef BREAK_DETECT_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_idx_n;
            shreg    <= shreg_n;
            ferr     <= ferr_n;
            perr     <= perr_n;
            stop_idx <= stop_idx_n;
`ifdef BREAK_DETECT_EN
            par_bit  <= par_bit_n;
`endif
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, otherwise untouched paths infer latches.
        state_n    = state;
        cnt_n      = cnt;
        bit_idx_n  = bit_idx;
        shreg_n    = shreg;
        ferr_n     = ferr;
        perr_n     = perr;
        stop_idx_n = stop_idx;
        push       = 1'b0;
        is_break   = 1'b0;
`ifdef BREAK_DETECT_EN
        par_bit_n  = par_bit;
`endif
        tick = (cnt == '0);

        if (state != S_IDLE && state != S_WAIT_HIGH)
            cnt_n = tick ? FULL_LOAD : cnt - 1'b1;

        unique case (state)
            S_IDLE: begin
                if (!rxs) begin
                    state_n = S_START;
                    cnt_n   = HALF_LOAD;
                end
            end
            S_START: begin
                if (tick) begin
                    if (!rxs) begin
                        state_n   = S_DATA;
                        bit_idx_n = '0;
                        perr_n    = 1'b0;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (tick) begin
                    shreg_n = {rxs, shreg[DATA_BITS-1:1]};
                    if (bit_idx == BW'(DATA_BITS - 1)) begin
                        state_n    = (PARITY != 0) ? S_PARITY : S_STOP;
                        stop_idx_n = 1'b0;
                        ferr_n     = 1'b0;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    perr_n  = ((^shreg) ^ rxs) != (PARITY == 1);
                    state_n = S_STOP;
`ifdef BREAK_DETECT_EN
                    par_bit_n = rxs;
`endif
                end
            end
            S_STOP: begin
                if (tick) begin
`ifdef BREAK_DETECT_EN
                    is_break = !stop_idx && shreg == '0 && (PARITY == 0 || !par_bit) && !rxs;
`endif
                    if (is_break) begin
                        state_n = S_WAIT_HIGH;
                    end else if (stop_idx == 1'(STOP_BITS - 1)) begin
                        push    = 1'b1;
                        state_n = (ferr || !rxs) ? S_WAIT_HIGH : S_IDLE;
                    end else begin
                        stop_idx_n = 1'b1;
                        ferr_n     = ferr | ~rxs;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (rxs) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign break_det = is_break;

    // Show-ahead FIFO: head entry is visible combinationally while non-empty.
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [EW-1:0] head;
    logic          full, pop, wr_en;

    assign full  = (fifo_count == (AW+1)'(FIFO_DEPTH));
    assign pop   = rx_valid && rx_ready;
    assign wr_en = push && (!full || pop);

    // NOTE: storage is not reset; occupancy is tracked by the reset pointers and count alone.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {perr, ferr | ~rxs, shreg};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overrun    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            unique case ({wr_en, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (push && full && !pop) overrun <= 1'b1;
            else if (clear_overrun)   overrun <= 1'b0;
        end
    end

    assign rx_valid      = (fifo_count != '0);
    assign head          = mem[rd_ptr];
    assign rx_word       = rx_valid ? head[DATA_BITS-1:0] : '0;
    assign rx_frame_err  = rx_valid & head[DATA_BITS];
    assign rx_parity_err = rx_valid & head[DATA_BITS+1];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: two instances (no parity, even parity) at 16 clocks per bit.
module tb_uart_rx_fifo;

    localparam int BIT_CLKS = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       rx0, rx1, ready0, ready1, clr0, clr1;
    logic [7:0] word0, word1;
    logic       ferr0, ferr1, perr0, perr1, valid0, valid1;
    logic       ovr0, ovr1, brk0, brk1;
    logic [2:0] cnt0, cnt1;

    uart_rx_fifo #(.CLOCK_HZ(1600), .BIT_RATE_HZ(100), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
        .clk(clk), .reset_n(reset_n), .rx_data(rx0), .rx_word(word0),
        .rx_frame_err(ferr0), .rx_parity_err(perr0), .rx_valid(valid0),
        .rx_ready(ready0), .overrun(ovr0), .clear_overrun(clr0),
        .fifo_count(cnt0), .break_det(brk0));

    uart_rx_fifo #(.CLOCK_HZ(1600), .BIT_RATE_HZ(100), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .reset_n(reset_n), .rx_data(rx1), .rx_word(word1),
        .rx_frame_err(ferr1), .rx_parity_err(perr1), .rx_valid(valid1),
        .rx_ready(ready1), .overrun(ovr1), .clear_overrun(clr1),
        .fifo_count(cnt1), .break_det(brk1));

    int         n_vec = 0;
    int         n_err = 0;
    int         brk_seen = 0;
    logic [9:0] q0[$];
    logic [9:0] q1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: one comparison per accepted head entry, {parity_err, frame_err, word}.
    always @(negedge clk) begin : mon0
        logic [9:0] e;
        if (reset_n && valid0 && ready0) begin
            if (q0.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb0_extra: got %0h, expected no entry", {perr0, ferr0, word0});
            end else begin
                e = q0.pop_front();
                check("sb0_entry", {22'd0, perr0, ferr0, word0}, {22'd0, e});
            end
        end
    end

    always @(negedge clk) begin : mon1
        logic [9:0] e;
        if (reset_n && valid1 && ready1) begin
            if (q1.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb1_extra: got %0h, expected no entry", {perr1, ferr1, word1});
            end else begin
                e = q1.pop_front();
                check("sb1_entry", {22'd0, perr1, ferr1, word1}, {22'd0, e});
            end
        end
    end

    always @(negedge clk) if (brk0) brk_seen++;

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int ch, input logic v, input int n);
        if (ch == 0) rx0 = v;
        else         rx1 = v;
        wait_clks(n);
    endtask

    // par < 0: no parity bit; otherwise par[0] is the parity bit sent.
    task automatic send(input int ch, input logic [7:0] d, input int par, input logic stop_v);
        drive(ch, 1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) drive(ch, d[i], BIT_CLKS);
        if (par >= 0) drive(ch, par[0], BIT_CLKS);
        drive(ch, stop_v, BIT_CLKS);
    endtask

    initial begin
        int b0;
        reset_n = 1'b0;
        rx0 = 1'b1; rx1 = 1'b1;
        ready0 = 1'b1; ready1 = 1'b1;
        clr0 = 1'b0; clr1 = 1'b0;
        wait_clks(3);
        @(negedge clk);
        check("rst_valid", valid0, 0);
        check("rst_count", cnt0, 0);
        check("rst_overrun", ovr0, 0);
        check("rst_break", brk0, 0);
        check("rst_word", {word0, ferr0, perr0}, 0);
        wait_clks(1);
        reset_n = 1'b1;
        wait_clks(4);

        // 1: single word, drained immediately
        q0.push_back(10'h055);
        send(0, 8'h55, -1, 1'b1);
        drive(0, 1'b1, BIT_CLKS);
        check("t1_count", cnt0, 0);
        check("t1_valid", valid0, 0);

        // 2: short low glitch rejected, then a real frame
        drive(0, 1'b0, 5);
        drive(0, 1'b1, 3 * BIT_CLKS);
        check("t2_glitch_count", cnt0, 0);
        q0.push_back(10'h0A3);
        send(0, 8'hA3, -1, 1'b1);
        drive(0, 1'b1, BIT_CLKS);

        // 3: fill past capacity with the consumer stalled
        ready0 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k <= 4) q0.push_back(10'(k));
            send(0, 8'(k), -1, 1'b1);
            drive(0, 1'b1, BIT_CLKS);
        end
        check("t3_count_full", cnt0, 4);
        check("t3_overrun", ovr0, 1);
        check("t3_valid", valid0, 1);
        ready0 = 1'b1;
        wait_clks(BIT_CLKS);
        check("t3_drained", cnt0, 0);
        check("t3_overrun_sticky", ovr0, 1);
        clr0 = 1'b1;
        wait_clks(1);
        clr0 = 1'b0;
        check("t3_overrun_clr", ovr0, 0);

        // 4: even parity on the second instance
        q1.push_back(10'h007);
        send(1, 8'h07, 1, 1'b1);
        drive(1, 1'b1, BIT_CLKS);
        q1.push_back(10'h207);
        send(1, 8'h07, 0, 1'b1);
        drive(1, 1'b1, BIT_CLKS);
        check("t4_count", cnt1, 0);

        // 5: framing error then line stuck low
        ready0 = 1'b0;
        q0.push_back(10'h13C);
        send(0, 8'h3C, -1, 1'b0);
        drive(0, 1'b0, 40);
        check("t5_one_entry", cnt0, 1);
        check("t5_ferr_head", ferr0, 1);
        drive(0, 1'b1, 2 * BIT_CLKS);
        check("t5_still_one", cnt0, 1);
        ready0 = 1'b1;
        wait_clks(4);
        check("t5_drained", cnt0, 0);

        // 6: break (12 bit times low)
        b0 = brk_seen;
`ifndef BREAK_DETECT_EN
        q0.push_back(10'h100);
`endif
        drive(0, 1'b0, 12 * BIT_CLKS);
        drive(0, 1'b1, 3 * BIT_CLKS);
`ifdef BREAK_DETECT_EN
        check("t6_break_pulses", brk_seen - b0, 1);
`else
        check("t6_break_pulses", brk_seen - b0, 0);
`endif
        check("t6_count", cnt0, 0);
        q0.push_back(10'h05A);
        send(0, 8'h5A, -1, 1'b1);
        drive(0, 1'b1, BIT_CLKS);

        // 6b: reset mid-frame abandons the frame
        drive(0, 1'b0, 6 * BIT_CLKS);
        reset_n = 1'b0;
        wait_clks(2);
        rx0 = 1'b1;
        reset_n = 1'b1;
        wait_clks(4 * BIT_CLKS);
        check("t6_rst_count", cnt0, 0);
        check("t6_rst_valid", valid0, 0);
        check("t6_rst_overrun", ovr0, 0);

        check("sb0_left", q0.size(), 0);
        check("sb1_left", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
